// File: rtl/spi_regbank_pkg.sv
// Shared types and helpers for the SPI register bank.
//   state_t     : frame FSM encoding
//   RW_WRITE/RW_READ : values of the leading rw bit of a frame
//   frame_len() : bits per frame (rw + address + data)
//   cnt_width() : bit-counter width able to hold 0..frame_len
package spi_regbank_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_DATA = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic RW_WRITE = 1'b1;
  localparam logic RW_READ  = 1'b0;

  function automatic int frame_len(input int addr_w, input int data_w);
    return 1 + addr_w + data_w;
  endfunction

  function automatic int cnt_width(input int flen);
    return $clog2(flen + 1);
  endfunction

endpackage

// File: rtl/spi_regbank_rw_sync_edge.sv
// Input synchroniser with edge detection for one asynchronous pin.
//   i_clk, i_rst_n : system clock, async active-low reset
//   i_async        : raw pin
//   o_level        : synchronised level
//   o_rise/o_fall  : one-clk pulses on synchronised level transitions
// RST_VAL sets the idle level the chain (and history flop) resets to, so
// leaving reset never produces a spurious edge.
module spi_sync_edge #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RST_VAL     = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_async,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_hist;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync <= {SYNC_STAGES{RST_VAL}};
      r_hist <= RST_VAL;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
      r_hist <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_level = r_sync[SYNC_STAGES-1];
  assign o_rise  = r_sync[SYNC_STAGES-1] & ~r_hist;
  assign o_fall  = ~r_sync[SYNC_STAGES-1] & r_hist;

endmodule

// File: rtl/spi_regbank_rw.sv
// SPI mode-0 peripheral with a writable/readable register bank.
// Frame (MSB first): rw | address[ADDR_W] | data[DATA_W].
//   clk, rst          : system clock, async active-low reset
//   sclk, cs, copi    : async SPI pins (synchronised internally)
//   cipo, cipo_oe     : read data and pad enable (driven only in read DATA)
//   regs_out          : flat bank, reg k at [k*DATA_W +: DATA_W]
//   wr_strobe/wr_addr : commit pulse and address of last committed write
//   frame_err         : pulse when cs rises mid-frame
//
// state   | meaning
// IDLE    | waiting for cs fall
// CMD     | shifting in rw bit and address
// DATA    | shifting data in (write) or out on cipo (read)
// DONE    | frame complete, ignoring sclk until cs rises
module spi_regbank_rw
  import spi_regbank_pkg::*;
#(
  parameter int ADDR_W      = 7,
  parameter int DATA_W      = 8,
  parameter int NUM_REGS    = 5,
  parameter int SYNC_STAGES = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       sclk,
  input  logic                       cs,
  input  logic                       copi,
  output logic                       cipo,
  output logic                       cipo_oe,
  output logic [NUM_REGS*DATA_W-1:0] regs_out,
  output logic                       wr_strobe,
  output logic [ADDR_W-1:0]          wr_addr,
  output logic                       frame_err
);

  localparam int FLEN  = frame_len(ADDR_W, DATA_W);
  localparam int CNT_W = cnt_width(FLEN);
  localparam logic [CNT_W-1:0]  CNT_LAST_ADDR = CNT_W'(ADDR_W);
  localparam logic [CNT_W-1:0]  CNT_LAST      = CNT_W'(FLEN - 1);
  localparam logic [CNT_W-1:0]  CNT_SAT       = CNT_W'(FLEN);
  localparam logic [CNT_W-1:0]  CNT_ONE       = CNT_W'(1);
  localparam logic [ADDR_W:0]   NUM_REGS_L    = (ADDR_W+1)'(NUM_REGS);

  logic w_sclk_lvl, w_sclk_rise, w_sclk_fall;
  logic w_cs_lvl, w_cs_rise, w_cs_fall;
  logic w_copi_lvl, w_copi_rise, w_copi_fall;
  logic w_unused;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .i_clk(clk), .i_rst_n(rst), .i_async(sclk),
    .o_level(w_sclk_lvl), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall));

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
    .i_clk(clk), .i_rst_n(rst), .i_async(cs),
    .o_level(w_cs_lvl), .o_rise(w_cs_rise), .o_fall(w_cs_fall));

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_copi (
    .i_clk(clk), .i_rst_n(rst), .i_async(copi),
    .o_level(w_copi_lvl), .o_rise(w_copi_rise), .o_fall(w_copi_fall));

  // Only edges of sclk and only the level of copi matter.
  assign w_unused = ^{w_sclk_lvl, w_copi_rise, w_copi_fall};

  state_t                 r_state, w_state_nxt;
  logic                   w_clear, w_abort, w_final;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_rw;
  logic [ADDR_W-1:0]      r_addr;
  logic [DATA_W-1:0]      r_wdata;
  logic [DATA_W-1:0]      r_sr;
  logic                   r_first;
  logic                   r_pend;
  logic [NUM_REGS*DATA_W-1:0] r_bank;
  logic                   r_wr_strobe;
  logic [ADDR_W-1:0]      r_wr_addr;
  logic                   r_frame_err;
  logic [DATA_W-1:0]      w_rd_snap;
  logic                   w_addr_ok;

  always_comb begin
    w_state_nxt = r_state;
    w_clear     = 1'b0;
    w_abort     = 1'b0;
    w_final     = 1'b0;
    if (w_cs_fall) begin
      // Also covers a restart seen outside IDLE.
      w_state_nxt = ST_CMD;
      w_clear     = 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: w_state_nxt = ST_IDLE;
        ST_CMD: begin
          if (w_cs_rise) begin
            w_state_nxt = ST_IDLE;
            w_abort     = 1'b1;
          end else if (w_sclk_rise && (r_cnt == CNT_LAST_ADDR)) begin
            w_state_nxt = ST_DATA;
          end
        end
        ST_DATA: begin
          // Final edge wins over a coincident cs rise: the frame completes.
          if (w_sclk_rise && (r_cnt == CNT_LAST)) begin
            w_state_nxt = ST_DONE;
            w_final     = 1'b1;
          end else if (w_cs_rise) begin
            w_state_nxt = ST_IDLE;
            w_abort     = 1'b1;
          end
        end
        ST_DONE: if (w_cs_lvl) w_state_nxt = ST_IDLE;
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_state_nxt;
  end

  assign w_addr_ok = ({1'b0, r_addr} < NUM_REGS_L);

  // Unimplemented addresses fall through to zero.
  always_comb begin
    w_rd_snap = '0;
    for (int k = 0; k < NUM_REGS; k++)
      if (r_addr == ADDR_W'(k)) w_rd_snap = r_bank[k*DATA_W +: DATA_W];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt       <= '0;
      r_rw        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_sr        <= '0;
      r_first     <= 1'b0;
      r_pend      <= 1'b0;
      r_bank      <= '0;
      r_wr_strobe <= 1'b0;
      r_wr_addr   <= '0;
      r_frame_err <= 1'b0;
    end else begin
      r_frame_err <= w_abort;
      r_pend      <= w_final && (r_rw == RW_WRITE);
      r_wr_strobe <= 1'b0;
      // Commit lands one clk after the last data bit was shifted in.
      if (r_pend && w_addr_ok) begin
        for (int k = 0; k < NUM_REGS; k++)
          if (r_addr == ADDR_W'(k)) r_bank[k*DATA_W +: DATA_W] <= r_wdata;
        r_wr_strobe <= 1'b1;
        r_wr_addr   <= r_addr;
      end
      if (w_clear) begin
        r_cnt   <= '0;
        r_rw    <= 1'b0;
        r_addr  <= '0;
        r_wdata <= '0;
        r_sr    <= '0;
        r_first <= 1'b1;
      end else begin
        if (w_sclk_rise && ((r_state == ST_CMD) || (r_state == ST_DATA)) &&
            (r_cnt != CNT_SAT))
          r_cnt <= r_cnt + CNT_ONE;
        if ((r_state == ST_CMD) && w_sclk_rise) begin
          if (r_cnt == '0) r_rw <= w_copi_lvl;
          else             r_addr <= {r_addr[ADDR_W-2:0], w_copi_lvl};
        end
        if ((r_state == ST_DATA) && w_sclk_rise && (r_rw == RW_WRITE))
          r_wdata <= {r_wdata[DATA_W-2:0], w_copi_lvl};
        if ((r_state == ST_DATA) && w_sclk_fall) begin
          if (r_first) begin
            r_sr    <= w_rd_snap;
            r_first <= 1'b0;
          end else begin
            r_sr <= {r_sr[DATA_W-2:0], 1'b0};
          end
        end
      end
    end
  end

  assign cipo_oe   = (r_state == ST_DATA) && (r_rw == RW_READ);
  assign cipo      = cipo_oe & r_sr[DATA_W-1];
  assign regs_out  = r_bank;
  assign wr_strobe = r_wr_strobe;
  assign wr_addr   = r_wr_addr;
  assign frame_err = r_frame_err;

endmodule

// File: tb/tb_spi_regbank_rw.sv
module tb_spi_regbank_rw;

  localparam int ADDR_W = 7;
  localparam int DATA_W = 8;
  localparam int NUM_REGS = 5;
  localparam int SYNC_STAGES = 2;
  localparam int HALF = 6;
  localparam int K_WR = 0;
  localparam int K_RD = 1;
  localparam int K_ERR = 2;

  typedef struct {
    int         kind;
    logic [6:0] addr;
    logic [7:0] data;
    logic [15:0] oe;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic sclk = 1'b0;
  logic cs = 1'b1;
  logic copi = 1'b0;
  logic cipo, cipo_oe, wr_strobe, frame_err;
  logic [NUM_REGS*DATA_W-1:0] regs_out;
  logic [ADDR_W-1:0] wr_addr;

  int n_checks = 0;
  int n_fail = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  spi_regbank_rw #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .clk(clk), .rst(rst), .sclk(sclk), .cs(cs), .copi(copi),
    .cipo(cipo), .cipo_oe(cipo_oe), .regs_out(regs_out),
    .wr_strobe(wr_strobe), .wr_addr(wr_addr), .frame_err(frame_err)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  function automatic void push(input int kind, input logic [6:0] addr,
                               input logic [7:0] data, input logic [15:0] oe);
    exp_t e;
    e.kind = kind; e.addr = addr; e.data = data; e.oe = oe;
    exp_q.push_back(e);
  endfunction

  task automatic sb_pop(input int kind, input string name, output exp_t it, output bit ok);
    n_checks++;
    ok = 1'b0;
    it = '{kind: -1, addr: '0, data: '0, oe: '0};
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s: got unexpected event, required nothing (queue empty)", name);
    end else if (exp_q[0].kind != kind) begin
      n_fail++;
      $display("FAIL %s: got event kind %0d, required kind %0d", name, kind, exp_q[0].kind);
      void'(exp_q.pop_front());
    end else begin
      it = exp_q.pop_front();
      ok = 1'b1;
    end
  endtask

  // Monitor: runs on the inactive clock edge; stimulus moves 2 ns after posedge.
  logic       m_prev_sclk = 1'b0;
  logic       m_prev_cs = 1'b1;
  int         m_bit = 0;
  logic       m_rw = 1'b1;
  logic [7:0] m_rd = '0;
  logic [15:0] m_oe = '0;

  always @(negedge clk) begin : monitor
    exp_t it;
    bit ok;
    if (!rst) begin
      m_prev_sclk = 1'b0;
      m_prev_cs = 1'b1;
      m_bit = 0;
    end else begin
      if (m_prev_cs && !cs) begin
        m_bit = 0; m_rw = 1'b1; m_rd = '0; m_oe = '0;
      end
      if (!cs && sclk && !m_prev_sclk) begin
        if (m_bit == 0) m_rw = copi;
        if (m_bit < 16) m_oe = {m_oe[14:0], cipo_oe};
        if (m_bit >= 8 && m_bit < 16) m_rd = {m_rd[6:0], cipo};
        m_bit++;
        if (m_bit == 16 && m_rw == 1'b0) begin
          sb_pop(K_RD, "read_event", it, ok);
          if (ok) begin
            check("read_data", m_rd, it.data);
            check("read_oe_window", m_oe, it.oe);
          end
        end
      end
      m_prev_sclk = sclk;
      m_prev_cs = cs;
      if (wr_strobe) begin
        sb_pop(K_WR, "wr_strobe_event", it, ok);
        if (ok) begin
          check("wr_addr", wr_addr, it.addr);
          check("wr_reg_value", regs_out[int'(it.addr)*8 +: 8], it.data);
        end
      end
      if (frame_err) sb_pop(K_ERR, "frame_err_event", it, ok);
      if (!cipo_oe) check("cipo_quiet", cipo, 1'b0);
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic spi_frame(input logic [31:0] bits, input int nbits, input int gap);
    cs = 1'b0;
    tick(4);
    for (int i = 0; i < nbits; i++) begin
      copi = bits[nbits-1-i];
      tick(HALF);
      sclk = 1'b1;
      tick(HALF);
      sclk = 1'b0;
    end
    tick(HALF);
    cs = 1'b1;
    copi = 1'b0;
    tick(gap);
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: got timeout, required end of stimulus");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [15:0] f;
    tick(5);
    check("rst_cipo", cipo, 1'b0);
    check("rst_cipo_oe", cipo_oe, 1'b0);
    check("rst_regs", regs_out, 40'h0);
    check("rst_wr_strobe", wr_strobe, 1'b0);
    check("rst_wr_addr", wr_addr, 7'h0);
    check("rst_frame_err", frame_err, 1'b0);
    rst = 1'b1;
    tick(5);

    // write reg2 = A5, then read it back
    push(K_WR, 7'd2, 8'hA5, 16'h0);
    spi_frame({1'b1, 7'd2, 8'hA5}, 16, 8);
    check("t1_regs", regs_out, 40'h00_00_A5_00_00);
    push(K_RD, 7'd2, 8'hA5, 16'h00FF);
    spi_frame({1'b0, 7'd2, 8'h00}, 16, 8);

    // unimplemented address: no commit, reads as zero
    spi_frame({1'b1, 7'h7F, 8'hFF}, 16, 8);
    check("t3_regs_unchanged", regs_out, 40'h00_00_A5_00_00);
    push(K_RD, 7'h7F, 8'h00, 16'h00FF);
    spi_frame({1'b0, 7'h7F, 8'h00}, 16, 8);

    // abort after 10 bits, then a full write to reg1
    push(K_ERR, 7'd1, 8'h00, 16'h0);
    f = {1'b1, 7'd1, 8'hC3};
    spi_frame(32'(f >> 6), 10, 8);
    check("t4_regs_after_abort", regs_out, 40'h00_00_A5_00_00);
    push(K_WR, 7'd1, 8'h3C, 16'h0);
    spi_frame({1'b1, 7'd1, 8'h3C}, 16, 8);
    check("t4_regs_after_write", regs_out, 40'h00_00_A5_3C_00);

    // 20-bit frame, then back-to-back frame after a 1-clk cs gap
    push(K_WR, 7'd4, 8'h80, 16'h0);
    spi_frame({1'b1, 7'd4, 8'h80, 4'hF}, 20, 1);
    push(K_WR, 7'd3, 8'h5A, 16'h0);
    spi_frame({1'b1, 7'd3, 8'h5A}, 16, 8);
    check("t5_regs", regs_out, 40'h80_5A_A5_3C_00);

    // reset in the middle of a data phase
    push(K_WR, 7'd0, 8'h11, 16'h0);
    spi_frame({1'b1, 7'd0, 8'h11}, 16, 8);
    check("t6_regs_before_rst", regs_out, 40'h80_5A_A5_3C_11);
    f = {1'b1, 7'd2, 8'h77};
    cs = 1'b0;
    tick(4);
    for (int i = 0; i < 12; i++) begin
      copi = f[15-i];
      tick(HALF);
      sclk = 1'b1;
      tick(HALF);
      sclk = 1'b0;
    end
    rst = 1'b0;
    cs = 1'b1;
    copi = 1'b0;
    tick(3);
    check("t6_rst_regs", regs_out, 40'h0);
    check("t6_rst_cipo_oe", cipo_oe, 1'b0);
    check("t6_rst_wr_strobe", wr_strobe, 1'b0);
    check("t6_rst_frame_err", frame_err, 1'b0);
    rst = 1'b1;
    tick(4);
    push(K_RD, 7'd0, 8'h00, 16'h00FF);
    spi_frame({1'b0, 7'd0, 8'h00}, 16, 8);
    push(K_WR, 7'd1, 8'h42, 16'h0);
    spi_frame({1'b1, 7'd1, 8'h42}, 16, 8);
    push(K_RD, 7'd1, 8'h42, 16'h00FF);
    spi_frame({1'b0, 7'd1, 8'hFF}, 16, 8);
    check("t6_regs_after", regs_out, 40'h00_00_00_42_00);

    tick(10);
    check("scoreboard_drained", 64'(exp_q.size()), 64'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
